// File: rtl/pc_pkg.sv
// Shared types for the program-counter / relative-branch unit.
package pc_pkg;

   localparam int PC_DEFAULT_W = 16;

   typedef enum logic {
      IDLE   = 1'b0,
      FIX_HI = 1'b1
   } pc_state_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } pc_dir_e;

endpackage : pc_pkg

// File: rtl/pc_branch_unit.sv
// Program counter with increment, parallel load and 6502-style relative
// branch: the low half (page offset) is updated on the first edge, and the
// high half gets a one-cycle fix-up only when the branch crosses a page.
module pc_branch_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W      = PC_DEFAULT_W,
   parameter int                OFF_W       = 8,
   parameter logic [ADDR_W-1:0] RESET_VALUE = {ADDR_W{1'b0}}
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sync_clr,
   input  logic                  load,
   input  logic [ADDR_W/2-1:0]   pc_lo_in,
   input  logic [ADDR_W/2-1:0]   pc_hi_in,
   input  logic                  inc_en,
   input  logic                  branch_req,
   input  logic [OFF_W-1:0]      branch_off,
   output logic [ADDR_W/2-1:0]   pc_lo_out,
   output logic [ADDR_W/2-1:0]   pc_hi_out,
   output logic                  branch_busy,
   output logic                  page_cross,
   output logic                  branch_done
);

   localparam int HALF = ADDR_W / 2;

   pc_state_e          state_q, state_d;
   pc_dir_e            dir_q, dir_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic               page_cross_q, page_cross_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Page adder: sign-extended offset added to the low half with carry out.
   logic signed [OFF_W-1:0] off_signed_s;
   logic [HALF-1:0]         off_ext_s;
   logic [HALF:0]           page_sum_s;
   logic                    cross_s;

   assign off_signed_s = branch_off;
   assign off_ext_s    = HALF'(off_signed_s);
   assign page_sum_s   = {1'b0, pc_q[HALF-1:0]} + {1'b0, off_ext_s};
   // Forward branch crosses on carry out; backward branch crosses on no carry.
   assign cross_s      = off_ext_s[HALF-1] ? ~page_sum_s[HALF] : page_sum_s[HALF];

   // Next-state selection in priority order: clear, load, fix-up, branch, increment.
   always_comb begin
      pc_d         = pc_q;
      state_d      = state_q;
      dir_d        = dir_q;
      page_cross_d = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      if (sync_clr) begin
         pc_d    = RESET_VALUE;
         state_d = IDLE;
      end else if (load) begin
         pc_d    = {pc_hi_in, pc_lo_in};
         state_d = IDLE;
      end else if (state_q == FIX_HI) begin
         if (dir_q == DIR_DOWN) begin
            pc_d[ADDR_W-1:HALF] = pc_q[ADDR_W-1:HALF] - HALF'(1'b1);
         end else begin
            pc_d[ADDR_W-1:HALF] = pc_q[ADDR_W-1:HALF] + HALF'(1'b1);
         end
         state_d = IDLE;
         done_d  = 1'b1;
      end else if (branch_req) begin
         pc_d[HALF-1:0] = page_sum_s[HALF-1:0];
         if (cross_s) begin
            state_d      = FIX_HI;
            dir_d        = off_ext_s[HALF-1] ? DIR_DOWN : DIR_UP;
            page_cross_d = 1'b1;
            busy_d       = 1'b1;
         end else begin
            done_d = 1'b1;
         end
      end else if (inc_en) begin
         pc_d = pc_q + ADDR_W'(1'b1);
      end else begin
         pc_d = pc_q;
      end
   end

   // State and registered outputs; async reset to RESET_VALUE in IDLE.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q         <= RESET_VALUE;
         state_q      <= IDLE;
         dir_q        <= DIR_UP;
         page_cross_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         pc_q         <= pc_d;
         state_q      <= state_d;
         dir_q        <= dir_d;
         page_cross_q <= page_cross_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign pc_lo_out   = pc_q[HALF-1:0];
   assign pc_hi_out   = pc_q[ADDR_W-1:HALF];
   assign branch_busy = busy_q;
   assign page_cross  = page_cross_q;
   assign branch_done = done_q;

endmodule : pc_branch_unit
